// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM encoding, frame width, baud helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StCleanup
  } uart_state_e;

  // Integer division: any fractional part of the bit period is dropped.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for the asynchronous RX line; resets to the idle level (1).
module uart_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with centre-of-bit sampling and a one-cycle data_valid strobe.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote around the bit centre.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 serial_data_in,
  output logic [DATA_BITS-1:0] parallel_data_out,
  output logic                 busy,
  output logic                 data_valid
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned SAMPLE_DELAY = 1;
`else
  localparam int unsigned SAMPLE_DELAY = 0;
`endif
  // The majority decision lands one clock after the centre; only the start wait absorbs it.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1 + SAMPLE_DELAY);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 rx_sync;
  logic                 rx_sample;
  logic [SAMPLE_DELAY:0] rx_hist_q;

  uart_sync_2ff u_sync (
    .clk (sys_clk),
    .rst (rst),
    .d   (serial_data_in),
    .q   (rx_sync)
  );

`ifdef UART_RX_MAJORITY_EN
  assign rx_sample = (rx_sync & rx_hist_q[0]) | (rx_sync & rx_hist_q[1]) |
                     (rx_hist_q[0] & rx_hist_q[1]);
`else
  assign rx_sample = rx_sync;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_hist_q[0] && !rx_sync) begin
          state_d = StStart;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == START_LAST) begin
          cnt_d = '0;
          if (!rx_sample) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StData: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_sample;
          if (bit_idx_q == IDX_LAST) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStop: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = StCleanup;
          // A low stop bit is a framing error: the byte is dropped silently.
          if (rx_sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCleanup: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      rx_hist_q <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
`ifdef UART_RX_MAJORITY_EN
      rx_hist_q <= {rx_hist_q[0], rx_sync};
`else
      rx_hist_q <= rx_sync;
`endif
    end
  end

  assign parallel_data_out = data_q;
  assign busy              = busy_q;
  assign data_valid        = valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 50 MHz / 115200 baud (434 clocks per bit).
module tb_uart_receiver;

  localparam int CLK_HALF = 10;
  localparam int BIT_T    = 434 * 2 * CLK_HALF;
  // data_valid lands ~9.5 bit periods plus a few sync/register clocks after the start edge.
  localparam int LAT_MIN  = 82400;
  localparam int LAT_MAX  = 82700;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       serial_data_in;
  logic [7:0] parallel_data_out;
  logic       busy;
  logic       data_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int         valid_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  logic       prev_valid = 1'b0;
  logic       multi_cycle = 1'b0;
  logic       busy_seen = 1'b0;
  logic       busy_at_valid = 1'b0;
  logic       busy_after_valid = 1'b1;
  longint     fall_time = 0;
  longint     valid_time = 0;

  uart_receiver dut (
    .sys_clk           (sys_clk),
    .rst               (rst),
    .serial_data_in    (serial_data_in),
    .parallel_data_out (parallel_data_out),
    .busy              (busy),
    .data_valid        (data_valid)
  );

  always #CLK_HALF sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (busy) busy_seen = 1'b1;
    if (prev_valid) busy_after_valid = busy;
    if (data_valid) begin
      if (prev_valid) multi_cycle = 1'b1;
      valid_cnt++;
      last_byte     = parallel_data_out;
      valid_time    = $time;
      busy_at_valid = busy;
    end
    prev_valid = data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fall_time      = $time;
    serial_data_in = 1'b0;
    #BIT_T;
    for (int i = 0; i < 8; i++) begin
      serial_data_in = b[i];
      #BIT_T;
    end
    serial_data_in = stop_bit;
    #BIT_T;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    serial_data_in = 1'b0;
    #BIT_T;
    for (int i = 0; i < nbits; i++) begin
      serial_data_in = b[i];
      #BIT_T;
    end
  endtask

  initial begin
    longint lat;

    // 1: reset state, then an idle line
    rst            = 1'b1;
    serial_data_in = 1'b1;
    #100;
    check("reset_out", parallel_data_out, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_valid", data_valid, 1'b0);
    rst = 1'b0;
    #(2 * BIT_T);
    check("idle_busy_seen", busy_seen, 1'b0);
    check("idle_valid_cnt", valid_cnt, 0);

    // 2: single frame 0x2D
    send_frame(8'h2D, 1'b1);
    check("f2d_cnt", valid_cnt, 1);
    check("f2d_byte", last_byte, 8'h2D);
    check("f2d_out", parallel_data_out, 8'h2D);
    lat = valid_time - fall_time;
    check("f2d_latency_ok", (lat >= LAT_MIN && lat <= LAT_MAX), 1'b1);
    check("f2d_one_cycle", multi_cycle, 1'b0);
    check("f2d_busy_at_valid", busy_at_valid, 1'b1);
    check("f2d_busy_after", busy_after_valid, 1'b0);
    check("f2d_busy_idle", busy, 1'b0);
    #BIT_T;

    // 3: back-to-back 0x55, 0xA3
    send_frame(8'h55, 1'b1);
    check("f55_cnt", valid_cnt, 2);
    check("f55_byte", last_byte, 8'h55);
    send_frame(8'hA3, 1'b1);
    check("fa3_cnt", valid_cnt, 3);
    check("fa3_byte", last_byte, 8'hA3);
    check("fa3_out", parallel_data_out, 8'hA3);
    #BIT_T;

    // 4: 2 us glitch is a false start
    busy_seen      = 1'b0;
    serial_data_in = 1'b0;
    #2000;
    serial_data_in = 1'b1;
    #(2 * BIT_T);
    check("glitch_busy_seen", busy_seen, 1'b1);
    check("glitch_busy", busy, 1'b0);
    check("glitch_cnt", valid_cnt, 3);

    // 5: framing error on 0x3C, then a good 0x81
    send_frame(8'h3C, 1'b0);
    serial_data_in = 1'b1;
    #BIT_T;
    check("ferr_cnt", valid_cnt, 3);
    check("ferr_out", parallel_data_out, 8'hA3);
    send_frame(8'h81, 1'b1);
    check("f81_cnt", valid_cnt, 4);
    check("f81_out", parallel_data_out, 8'h81);
    #BIT_T;

    // 6: reset mid-frame after bit 3, then 0x7E
    send_partial(8'hF5, 4);
    #(BIT_T / 2);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", data_valid, 1'b0);
    check("midrst_out", parallel_data_out, 8'h00);
    #19;
    serial_data_in = 1'b1;
    #40;
    rst = 1'b0;
    #BIT_T;
    send_frame(8'h7E, 1'b1);
    check("f7e_cnt", valid_cnt, 5);
    check("f7e_out", parallel_data_out, 8'h7E);
    check("f7e_one_cycle", multi_cycle, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
